throw_ctl_multi: RTL and testbench
==================================

Name: throw_ctl_multi

Overview:
Parametrised successor of the single-player throw controller. Generates the projectile trajectory (x, y) for either player (left or right thrower), using a per-throw launch velocity, base horizontal speed, wind and start position. Adds direction, screen-edge detection, abort, and a valid/done handshake for the draw and collision logic. Sits between the game FSM (start/abort) and the projectile sprite/hit-test blocks.

Parameters:
POS_W, 12, width of x/y position ports and registers
VEL_W, 16, width of vertical velocity
SPD_W, 8, width of base/derived horizontal speed
WIND_W, 7, width of wind input
GRAVITY, 10, vertical velocity change per physics step
SLOWDOWN, 16, clock cycles per physics step (>=2)
WIND_CENTER, 50, wind value giving no horizontal correction
WIND_DIV, 25, wind deviation divisor
X_MAX, 1023, largest legal x coordinate

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  launch request; accepted only in IDLE
abort  in  1  cancel throw; return to IDLE
dir  in  1  0: x increases, 1: x decreases; latched at start
init_vel_y  in  VEL_W  launch vertical velocity; latched at start
base_speed_x  in  SPD_W  base horizontal speed; latched at start
wind  in  WIND_W  wind strength; latched at start
x_start  in  POS_W  launch x; latched at start
y_start  in  POS_W  launch height; latched at start
x_pos  out  POS_W  current x
y_pos  out  POS_W  current height above ground
busy  out  1  high from the cycle after start acceptance until return to IDLE
step_valid  out  1  one-cycle pulse each physics step; x_pos/y_pos updated the same cycle
done  out  1  one-cycle pulse at throw end (not on abort)
hit_ground  out  1  sticky: throw ended at y=0; cleared at next start acceptance
out_of_bounds  out  1  sticky: throw ended at x edge; cleared at next start acceptance

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0, tick counter 0.
- States: IDLE, RISE, FALL, DONE.
- IDLE: start=1 -> latch inputs; x=x_start, y=y_start, vy=init_vel_y; clear sticky flags; tick=0; go RISE. x_pos/y_pos show the start values from the next cycle. start in any other state is ignored.
- speed_x at start: wind>=WIND_CENTER: base+(wind-WIND_CENTER)/WIND_DIV, saturated at 2^SPD_W-1; else base-(WIND_CENTER-wind)/WIND_DIV, saturated at 0. Integer division, truncating.
- Tick: counter counts 0..SLOWDOWN-1 in RISE/FALL; a step occurs on the cycle the counter equals SLOWDOWN-1, and the counter wraps to 0. The first step occurs SLOWDOWN cycles after start acceptance.
- RISE step: y = y+vy, saturated at 2^POS_W-1. If vy>GRAVITY then vy = vy-GRAVITY; else vy=0 and go FALL.
- FALL step: if y>vy then y = y-vy; else y=0 and the throw ends with hit_ground. vy = vy+GRAVITY, saturated at 2^VEL_W-1.
- x on every step: dir=0 gives x+speed_x; if this exceeds X_MAX, x=X_MAX and the throw ends with out_of_bounds. dir=1 gives x-speed_x; if this underflows, x=0 and the throw ends with out_of_bounds.
- If both end conditions occur on one step, both flags set.
- On each step, step_valid=1 and x_pos/y_pos carry the new values (no one-step lag).
- End of throw -> DONE for one cycle: done=1, then IDLE. busy drops in the IDLE cycle. Positions hold their final values in IDLE.
- abort=1 in RISE/FALL/DONE -> IDLE on the next edge, with no done or step_valid pulse. Positions hold and flags are unchanged. abort has priority over a simultaneous step. abort in IDLE has no effect.
- Reset asserted mid-throw: immediate return to the reset state.

Test Plan:
1. GRAVITY=10, SLOWDOWN=4, init_vel_y=30, base=5, wind=50, dir=0, x_start=100, y_start=0 -> 7 step_valid pulses 4 cycles apart. y sequence 30,50,60,60,50,30,0; x ends at 135; done one cycle after the 7th step; hit_ground=1; busy low afterwards.
2. Wind: base=5, wind=100 -> speed 7; wind=0 -> speed 3; base=1, wind=0 -> speed 0 (x constant across all steps).
3. X_MAX=120, dir=0, x_start=100, speed 7, init_vel_y=200 -> x 107, 114, 120 (clamped); out_of_bounds=1, hit_ground=0, done on step 3. Mirror case: dir=1, x_start=10 -> x 3, 0; out_of_bounds=1.
4. Abort asserted at step 3 of scenario 1 -> IDLE next cycle, no done pulse, x_pos=115, y_pos=60 held. A new start is then accepted and clears the flags.
5. start pulsed while busy -> ignored, trajectory unchanged. rst low mid-FALL -> all outputs 0 immediately, state IDLE.
6. y saturation: POS_W=8, y_start=250, init_vel_y=30 -> y=255 after step 1; throw still terminates with hit_ground.

Source files
------------

// File: rtl/throw_ctl_multi_if.sv
// Throw request/trajectory bundle between the game FSM (master) and the throw controller (slave).
interface throw_ctl_multi_if #(
  parameter int POS_W  = 12,
  parameter int VEL_W  = 16,
  parameter int SPD_W  = 8,
  parameter int WIND_W = 7
);
  logic              start;
  logic              abort;
  logic              dir;
  logic [VEL_W-1:0]  init_vel_y;
  logic [SPD_W-1:0]  base_speed_x;
  logic [WIND_W-1:0] wind;
  logic [POS_W-1:0]  x_start;
  logic [POS_W-1:0]  y_start;
  logic [POS_W-1:0]  x_pos;
  logic [POS_W-1:0]  y_pos;
  logic              busy;
  logic              step_valid;
  logic              done;
  logic              hit_ground;
  logic              out_of_bounds;

  modport master (
    output start, abort, dir, init_vel_y, base_speed_x, wind, x_start, y_start,
    input  x_pos, y_pos, busy, step_valid, done, hit_ground, out_of_bounds
  );
  modport slave (
    input  start, abort, dir, init_vel_y, base_speed_x, wind, x_start, y_start,
    output x_pos, y_pos, busy, step_valid, done, hit_ground, out_of_bounds
  );
endinterface

// File: rtl/throw_ctl_multi.sv
// Projectile trajectory generator for either thrower: rise/fall physics stepped every
// SLOWDOWN cycles, wind-corrected horizontal speed, edge/ground termination and abort.
module throw_ctl_multi #(
  parameter int POS_W       = 12,
  parameter int VEL_W       = 16,
  parameter int SPD_W       = 8,
  parameter int WIND_W      = 7,
  parameter int GRAVITY     = 10,
  parameter int SLOWDOWN    = 16,
  parameter int WIND_CENTER = 50,
  parameter int WIND_DIV    = 25,
  parameter int X_MAX       = 1023
) (
  input logic              clk,
  input logic              rst,
  throw_ctl_multi_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RISE, FALL, DONE} state_e;

  localparam int TICK_W = $clog2(SLOWDOWN);
  localparam int YS_W   = ((POS_W > VEL_W) ? POS_W : VEL_W) + 1;
  localparam int XS_W   = ((POS_W > SPD_W) ? POS_W : SPD_W) + 1;
  localparam logic [31:0] WC      = 32'(WIND_CENTER);
  localparam logic [31:0] WD      = 32'(WIND_DIV);
  localparam logic [31:0] SPD_MAX = 32'((64'd1 << SPD_W) - 64'd1);

  state_e             state_q;
  logic [TICK_W-1:0]  tick_q;
  logic [POS_W-1:0]   x_q, y_q;
  logic [VEL_W-1:0]   vy_q;
  logic [SPD_W-1:0]   spd_q, spd_d;
  logic               dir_q, busy_q, step_q, done_q, hit_q, oob_q;

  // Wind correction is applied once at launch so the step datapath stays add/sub only.
  logic [31:0] w32, b32, dev, spd32;
  always_comb begin
    w32   = 32'(bus.wind);
    b32   = 32'(bus.base_speed_x);
    dev   = '0;
    spd32 = '0;
    spd_d = '0;
    if (w32 >= WC) begin
      dev   = (w32 - WC) / WD;
      spd32 = b32 + dev;
      spd_d = (spd32 > SPD_MAX) ? '1 : SPD_W'(spd32);
    end else begin
      dev   = (WC - w32) / WD;
      spd_d = (dev >= b32) ? '0 : SPD_W'(b32 - dev);
    end
  end

  logic [YS_W-1:0]  y_sum;
  logic [VEL_W:0]   vy_sum;
  logic [XS_W-1:0]  x_inc;
  logic [POS_W-1:0] y_rise, y_fall, x_step, y_step;
  logic [VEL_W-1:0] vy_rise, vy_fall, vy_step;
  logic             to_fall, ground, x_hi, x_lo, x_edge, y_end, step_now;

  assign y_sum   = YS_W'(y_q) + YS_W'(vy_q);
  assign y_rise  = (|y_sum[YS_W-1:POS_W]) ? '1 : y_sum[POS_W-1:0];
  assign to_fall = vy_q <= VEL_W'(GRAVITY);
  assign vy_rise = to_fall ? '0 : vy_q - VEL_W'(GRAVITY);

  // When not grounded vy < y, so the narrowing of vy cannot lose bits.
  assign ground  = YS_W'(y_q) <= YS_W'(vy_q);
  assign y_fall  = ground ? '0 : y_q - POS_W'(vy_q);
  assign vy_sum  = {1'b0, vy_q} + (VEL_W+1)'(GRAVITY);
  assign vy_fall = vy_sum[VEL_W] ? '1 : vy_sum[VEL_W-1:0];

  assign x_inc  = XS_W'(x_q) + XS_W'(spd_q);
  assign x_hi   = x_inc > XS_W'(X_MAX);
  assign x_lo   = XS_W'(x_q) < XS_W'(spd_q);
  assign x_edge = dir_q ? x_lo : x_hi;
  assign x_step = dir_q ? (x_lo ? '0 : x_q - POS_W'(spd_q))
                        : (x_hi ? POS_W'(X_MAX) : x_inc[POS_W-1:0]);

  assign y_step   = (state_q == RISE) ? y_rise : y_fall;
  assign vy_step  = (state_q == RISE) ? vy_rise : vy_fall;
  assign y_end    = (state_q == FALL) && ground;
  assign step_now = tick_q == TICK_W'(SLOWDOWN - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      vy_q    <= '0;
      spd_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          x_q     <= bus.x_start;
          y_q     <= bus.y_start;
          vy_q    <= bus.init_vel_y;
          spd_q   <= spd_d;
          dir_q   <= bus.dir;
          hit_q   <= 1'b0;
          oob_q   <= 1'b0;
          tick_q  <= '0;
          busy_q  <= 1'b1;
          state_q <= RISE;
        end
        RISE, FALL: begin
          if (bus.abort) begin
            tick_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (step_now) begin
            tick_q <= '0;
            step_q <= 1'b1;
            x_q    <= x_step;
            y_q    <= y_step;
            vy_q   <= vy_step;
            if (y_end || x_edge) begin
              hit_q   <= y_end;
              oob_q   <= x_edge;
              state_q <= DONE;
            end else if (state_q == RISE && to_fall) begin
              state_q <= FALL;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= !bus.abort;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x_pos         = x_q;
  assign bus.y_pos         = y_q;
  assign bus.busy          = busy_q;
  assign bus.step_valid    = step_q;
  assign bus.done          = done_q;
  assign bus.hit_ground    = hit_q;
  assign bus.out_of_bounds = oob_q;
endmodule

// File: tb/tb_throw_ctl_multi.sv
// Scoreboard bench: two controllers (12-bit/X_MAX 1023 and 8-bit/X_MAX 120), directed and
// random throws, expected steps produced by a plain-integer trajectory model.
module tb_throw_ctl_multi;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  throw_ctl_multi_if #(.POS_W(12)) if0 ();
  throw_ctl_multi_if #(.POS_W(8))  if1 ();

  throw_ctl_multi #(.SLOWDOWN(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  throw_ctl_multi #(.POS_W(8), .SLOWDOWN(4), .X_MAX(120)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic        start_s[2], abort_s[2], dir_s[2];
  logic [15:0] vy_s[2];
  logic [7:0]  base_s[2];
  logic [6:0]  wind_s[2];
  logic [11:0] x0_s[2], y0_s[2];
  logic [11:0] xo[2], yo[2];
  logic        busy_o[2], sv_o[2], dn_o[2], hg_o[2], ob_o[2];

  assign if0.start = start_s[0];  assign if1.start = start_s[1];
  assign if0.abort = abort_s[0];  assign if1.abort = abort_s[1];
  assign if0.dir   = dir_s[0];    assign if1.dir   = dir_s[1];
  assign if0.init_vel_y   = vy_s[0];   assign if1.init_vel_y   = vy_s[1];
  assign if0.base_speed_x = base_s[0]; assign if1.base_speed_x = base_s[1];
  assign if0.wind    = wind_s[0];  assign if1.wind    = wind_s[1];
  assign if0.x_start = x0_s[0];    assign if1.x_start = x0_s[1][7:0];
  assign if0.y_start = y0_s[0];    assign if1.y_start = y0_s[1][7:0];
  assign xo[0] = if0.x_pos;        assign xo[1] = {4'b0, if1.x_pos};
  assign yo[0] = if0.y_pos;        assign yo[1] = {4'b0, if1.y_pos};
  assign busy_o[0] = if0.busy;     assign busy_o[1] = if1.busy;
  assign sv_o[0] = if0.step_valid; assign sv_o[1] = if1.step_valid;
  assign dn_o[0] = if0.done;       assign dn_o[1] = if1.done;
  assign hg_o[0] = if0.hit_ground; assign hg_o[1] = if1.hit_ground;
  assign ob_o[0] = if0.out_of_bounds; assign ob_o[1] = if1.out_of_bounds;

  typedef struct {
    bit is_done;
    int t;
    int x;
    int y;
    bit hit;
    bit oob;
  } exp_t;

  exp_t sbq[2][$];
  exp_t traj[$];
  int   ntests = 0, nfail = 0;
  int   cyc = 0;
  int   t0[2], nsteps[2];
  bit   dn_seen[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int d, input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", d, name, act, exp, cyc);
    end
  endtask

  // Monitor: every step/done pulse must match the head of that DUT's expected queue.
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (sv_o[d] || dn_o[d]) begin
          exp_t e;
          if (sv_o[d]) nsteps[d]++;
          if (dn_o[d]) dn_seen[d] = 1'b1;
          if (sbq[d].size() == 0) begin
            ntests++; nfail++;
            $display("FAIL dut%0d unexpected_event: step=%0b done=%0b with empty queue", d, sv_o[d], dn_o[d]);
          end else begin
            e = sbq[d].pop_front();
            chk(d, "event_kind", int'(dn_o[d]), int'(e.is_done));
            chk(d, "event_time", cyc - t0[d], e.t);
            if (e.is_done) begin
              chk(d, "hit_ground", int'(hg_o[d]), int'(e.hit));
              chk(d, "out_of_bounds", int'(ob_o[d]), int'(e.oob));
              chk(d, "busy_at_done", int'(busy_o[d]), 0);
            end else begin
              chk(d, "step_x", int'(xo[d]), e.x);
              chk(d, "step_y", int'(yo[d]), e.y);
            end
          end
        end
      end
    end
  end

  // Reference trajectory: integer physics straight from the throw rules.
  task automatic build(input int d, input bit dir, input int vy0, input int base,
                       input int wind, input int x0, input int y0);
    int spd, x, y, vy, n, xmax, ymax;
    bit up, hit, oob;
    traj.delete();
    if (wind >= 50) spd = base + (wind - 50) / 25;
    else            spd = base - (50 - wind) / 25;
    if (spd > 255) spd = 255;
    if (spd < 0)   spd = 0;
    xmax = (d == 1) ? 120 : 1023;
    ymax = (d == 1) ? 255 : 4095;
    x = x0; y = y0; vy = vy0; up = 1; hit = 0; oob = 0; n = 0;
    while (!hit && !oob) begin
      n++;
      if (up) begin
        y = y + vy;
        if (y > ymax) y = ymax;
        if (vy > 10) vy = vy - 10;
        else begin vy = 0; up = 0; end
      end else begin
        if (y > vy) y = y - vy;
        else begin y = 0; hit = 1; end
        vy = vy + 10;
        if (vy > 65535) vy = 65535;
      end
      if (dir) x = x - spd;
      else     x = x + spd;
      if (x > xmax) begin x = xmax; oob = 1; end
      if (x < 0)    begin x = 0;    oob = 1; end
      traj.push_back('{1'b0, n * 4, x, y, 1'b0, 1'b0});
    end
    traj.push_back('{1'b1, n * 4 + 1, x, y, hit, oob});
  endtask

  task automatic chk_zero(input int d);
    chk(d, "rst_x", int'(xo[d]), 0);
    chk(d, "rst_y", int'(yo[d]), 0);
    chk(d, "rst_busy", int'(busy_o[d]), 0);
    chk(d, "rst_step", int'(sv_o[d]), 0);
    chk(d, "rst_done", int'(dn_o[d]), 0);
    chk(d, "rst_hit", int'(hg_o[d]), 0);
    chk(d, "rst_oob", int'(ob_o[d]), 0);
  endtask

  // kill: 0 run to completion, 1 abort after k steps, 2 reset after k steps.
  task automatic run_throw(input int d, input bit dir, input int vy, input int base,
                           input int wind, input int x0, input int y0,
                           input int kill_in, input int k_in, input bit poke);
    int n, k, kill, lim;
    kill = kill_in; k = k_in;
    build(d, dir, vy, base, wind, x0, y0);
    n = traj.size() - 1;
    if (kill != 0 && k >= n) k = n - 1;
    if (k < 1) kill = 0;
    for (int i = 0; i < traj.size(); i++)
      if (kill == 0 || i < k) sbq[d].push_back(traj[i]);

    @(posedge clk); #1;
    dir_s[d] = dir; vy_s[d] = 16'(vy); base_s[d] = 8'(base); wind_s[d] = 7'(wind);
    x0_s[d] = 12'(x0); y0_s[d] = 12'(y0); start_s[d] = 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0; t0[d] = cyc; nsteps[d] = 0; dn_seen[d] = 1'b0;
    chk(d, "start_busy", int'(busy_o[d]), 1);
    chk(d, "start_x", int'(xo[d]), x0);
    chk(d, "start_y", int'(yo[d]), y0);
    chk(d, "start_hit_clr", int'(hg_o[d]), 0);
    chk(d, "start_oob_clr", int'(ob_o[d]), 0);

    if (poke) begin
      @(posedge clk); #1;
      start_s[d] = 1'b1; x0_s[d] = 12'(x0 / 2); y0_s[d] = 12'(y0 + 7); vy_s[d] = 16'(vy + 40);
      @(posedge clk); #1;
      start_s[d] = 1'b0;
    end

    if (kill != 0) begin
      lim = 0;
      while (nsteps[d] < k && lim < 4000) begin @(negedge clk); lim++; end
      chk(d, "reach_kill_step", int'(nsteps[d] >= k), 1);
      @(posedge clk); #1;
      if (kill == 1) begin
        abort_s[d] = 1'b1;
        @(posedge clk); #1;
        abort_s[d] = 1'b0;
        chk(d, "abort_busy", int'(busy_o[d]), 0);
        repeat (6) @(negedge clk);
        chk(d, "abort_x_held", int'(xo[d]), traj[k-1].x);
        chk(d, "abort_y_held", int'(yo[d]), traj[k-1].y);
        chk(d, "abort_hit", int'(hg_o[d]), 0);
        chk(d, "abort_oob", int'(ob_o[d]), 0);
        chk(d, "abort_no_done", int'(dn_seen[d]), 0);
      end else begin
        rst = 1'b0;
        #1;
        chk_zero(0);
        chk_zero(1);
        sbq[0].delete();
        sbq[1].delete();
        @(posedge clk); #1;
        rst = 1'b1;
      end
    end else begin
      lim = 0;
      while (!dn_seen[d] && lim < 4000) begin @(negedge clk); lim++; end
      chk(d, "done_seen", int'(dn_seen[d]), 1);
      @(negedge clk);
      chk(d, "idle_busy", int'(busy_o[d]), 0);
    end
    chk(d, "queue_drained", sbq[d].size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 0; abort_s[d] = 0; dir_s[d] = 0; vy_s[d] = '0; base_s[d] = '0;
      wind_s[d] = '0; x0_s[d] = '0; y0_s[d] = '0; t0[d] = 0; nsteps[d] = 0; dn_seen[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0);
    chk_zero(1);
    rst = 1'b1;

    // Basic arc: y 30,50,60,60,50,30,0; x ends at 135.
    run_throw(0, 0, 30, 5, 50, 100, 0, 0, 0, 0);
    chk(0, "s1_x_end", int'(xo[0]), 135);
    chk(0, "s1_y_end", int'(yo[0]), 0);
    chk(0, "s1_hit", int'(hg_o[0]), 1);
    chk(0, "s1_oob", int'(ob_o[0]), 0);

    // Wind: speed 7, 3, and clamped to 0.
    run_throw(0, 0, 30, 5, 100, 100, 0, 0, 0, 0);
    chk(0, "wind100_x_end", int'(xo[0]), 149);
    run_throw(0, 0, 30, 5, 0, 100, 0, 0, 0, 0);
    chk(0, "wind0_x_end", int'(xo[0]), 121);
    run_throw(0, 0, 30, 1, 0, 100, 0, 0, 0, 0);
    chk(0, "speed0_x_end", int'(xo[0]), 100);
    run_throw(0, 1, 20, 254, 127, 1000, 5, 0, 0, 0);

    // Right edge clamp then left-edge mirror on the X_MAX=120 instance.
    run_throw(1, 0, 200, 5, 100, 100, 0, 0, 0, 0);
    chk(1, "edge_x", int'(xo[1]), 120);
    chk(1, "edge_oob", int'(ob_o[1]), 1);
    chk(1, "edge_hit", int'(hg_o[1]), 0);
    run_throw(1, 1, 200, 5, 100, 10, 0, 0, 0, 0);
    chk(1, "mirror_x", int'(xo[1]), 0);
    chk(1, "mirror_oob", int'(ob_o[1]), 1);

    // Height saturation on the 8-bit instance.
    run_throw(1, 0, 30, 0, 50, 50, 250, 0, 0, 0);
    chk(1, "ysat_hit", int'(hg_o[1]), 1);

    // Abort after step 3, then a fresh start clears things.
    run_throw(0, 0, 30, 5, 50, 100, 0, 1, 3, 0);
    chk(0, "abort_x_115", int'(xo[0]), 115);
    chk(0, "abort_y_60", int'(yo[0]), 60);
    run_throw(0, 0, 30, 5, 50, 100, 0, 0, 0, 1);

    // Reset mid-FALL.
    run_throw(0, 0, 30, 5, 50, 100, 0, 2, 4, 0);

    for (int i = 0; i < 50; i++) begin
      int d, kill, k;
      d = i % 2;
      kill = ($urandom_range(0, 4) == 0) ? 1 : 0;
      k = $urandom_range(1, 8);
      run_throw(d, 1'($urandom_range(0, 1)), $urandom_range(0, 200), $urandom_range(0, 255),
                $urandom_range(0, 127), (d == 1) ? $urandom_range(0, 120) : $urandom_range(0, 1023),
                (d == 1) ? $urandom_range(0, 255) : $urandom_range(0, 600),
                kill, k, 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
